// File: rtl/write_buffer_pkg.sv
// Shared CPU package: address/data width constants, the posted-write entry
// record used by the write buffer, and the read-path request/response types
// that query the buffer for pending writes.
package write_buffer_pkg;

    localparam int ADDR_W = 30;   // word address width
    localparam int DATA_W = 32;   // data word width
    localparam int BE_W   = DATA_W / 8;

    // One pending write: word address, data and per-byte enables.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   byte_enable;
    } wb_entry_t;

    // Read-path types.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } rd_resp_t;

endpackage

// File: rtl/write_buffer.sv
// write_buffer: in-order posted-write FIFO between the CPU and the bus.
//
// Ports:
//   clk, reset_n              single clock; synchronous active-low reset
//   push_valid/addr/data/byte_enable, push_ready
//                             CPU write offer and acceptance
//   bus_write_req, bus_addr, bus_data, bus_byte_enable, bus_ready
//                             head entry presented to the bus, popped on bus_ready
//   query_addr, query_hit     pending-write address match for CPU reads
//   count, empty              occupancy
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push_valid,
    input  logic [ADDR_W-1:0]         push_addr,
    input  logic [DATA_W-1:0]         push_data,
    input  logic [BE_W-1:0]           push_byte_enable,
    output logic                      push_ready,
    output logic                      bus_write_req,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_data,
    output logic [BE_W-1:0]           bus_byte_enable,
    input  logic                      bus_ready,
    input  logic [ADDR_W-1:0]         query_addr,
    output logic                      query_hit,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               do_push;
    logic               do_pop;
    logic [PTR_W-1:0]   slot_off;

    // push_ready depends on count only, so bus_ready never reaches it;
    // a pop on a full buffer frees the slot for the following cycle.
    assign push_ready    = (count != FULL_COUNT);
    assign empty         = (count == '0);
    assign bus_write_req = !empty;
    assign do_push       = push_valid && push_ready;
    assign do_pop        = bus_write_req && bus_ready;

    assign bus_addr        = mem[head].addr;
    assign bus_data        = mem[head].data;
    assign bus_byte_enable = mem[head].byte_enable;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= '{addr: push_addr, data: push_data,
                               byte_enable: push_byte_enable};
                tail      <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is pending when its distance from head is below count; the
    // head entry still counts during the cycle it is being popped.
    always_comb begin
        query_hit = 1'b0;
        slot_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - head;
            if (({1'b0, slot_off} < count) && (mem[i].addr == query_addr)) begin
                query_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;
    import write_buffer_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              push_valid;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic [BE_W-1:0]   push_byte_enable;
    logic              push_ready;
    logic              bus_write_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;
    logic [BE_W-1:0]   bus_byte_enable;
    logic              bus_ready;
    logic [ADDR_W-1:0] query_addr;
    logic              query_hit;
    logic [CW-1:0]     count;
    logic              empty;

    int n_run  = 0;
    int n_fail = 0;
    int m_count = 0;
    wb_entry_t sb[$];

    write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
        .push_byte_enable(push_byte_enable), .push_ready(push_ready),
        .bus_write_req(bus_write_req), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_byte_enable(bus_byte_enable), .bus_ready(bus_ready),
        .query_addr(query_addr), .query_hit(query_hit),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    task automatic set_push(input logic v, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        push_valid       = v;
        push_addr        = a;
        push_data        = d;
        push_byte_enable = be;
    endtask

    // One clock: the model decides push/pop from its own state, checks any
    // popped entry against the scoreboard head, then tracks count.
    task automatic tick();
        wb_entry_t exp_e;
        bit do_pop, do_push;
        do_pop  = 0;
        do_push = 0;
        if (!reset_n) begin
            sb.delete();
            m_count = 0;
        end else begin
            do_pop  = bus_ready && (m_count > 0);
            do_push = push_valid && (m_count < DEPTH);
            if (do_pop) begin
                exp_e = sb.pop_front();
                n_run++;
                if (bus_write_req !== 1'b1 || bus_addr !== exp_e.addr ||
                    bus_data !== exp_e.data || bus_byte_enable !== exp_e.byte_enable) begin
                    n_fail++;
                    $display("FAIL pop_entry: got req=%b addr=%h data=%h be=%h, want addr=%h data=%h be=%h",
                             bus_write_req, bus_addr, bus_data, bus_byte_enable,
                             exp_e.addr, exp_e.data, exp_e.byte_enable);
                end
            end
            if (do_push) sb.push_back('{addr: push_addr, data: push_data,
                                        byte_enable: push_byte_enable});
            m_count = m_count + int'(do_push) - int'(do_pop);
        end
        @(posedge clk);
        #1;
        n_run++;
        if (count !== CW'(m_count)) begin
            n_fail++;
            $display("FAIL count_track: got %0d want %0d", count, m_count);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus_ready  = 1'b0;
        query_addr = '0;
        set_push(1'b0, '0, '0, '0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        n_run++;
        if (empty !== 1'b1 || push_ready !== 1'b1 || bus_write_req !== 1'b0 ||
            bus_addr !== '0 || bus_data !== '0 || bus_byte_enable !== '0 ||
            query_hit !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got empty=%b ready=%b req=%b addr=%h data=%h be=%h hit=%b count=%0d, want 1 1 0 0 0 0 0 0",
                     empty, push_ready, bus_write_req, bus_addr, bus_data,
                     bus_byte_enable, query_hit, count);
        end
    endtask

    task automatic test_single();
        bus_ready = 1'b1;
        set_push(1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
        tick();
        set_push(1'b0, '0, '0, '0);
        n_run++;
        if (bus_write_req !== 1'b1 || bus_addr !== 30'h10 ||
            bus_data !== 32'hDEADBEEF || bus_byte_enable !== 4'hF) begin
            n_fail++;
            $display("FAIL single_latency: got req=%b addr=%h data=%h be=%h, want 1 10 deadbeef f",
                     bus_write_req, bus_addr, bus_data, bus_byte_enable);
        end
        tick();
        n_run++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_full_hold();
        bus_ready = 1'b0;
        set_push(1'b1, 30'h1, data_of(30'h1), 4'h3);
        tick();
        set_push(1'b1, 30'h2, data_of(30'h2), 4'h0);
        tick();
        set_push(1'b1, 30'h3, data_of(30'h3), 4'hC);
        n_run++;
        if (count !== CW'(2) || push_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got count=%0d ready=%b want 2 0", count, push_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_run++;
            if (bus_write_req !== 1'b1 || bus_addr !== 30'h1 ||
                bus_data !== data_of(30'h1) || bus_byte_enable !== 4'h3) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got req=%b addr=%h data=%h be=%h want 1 1 %h 3",
                         i, bus_write_req, bus_addr, bus_data, bus_byte_enable, data_of(30'h1));
            end
        end
    endtask

    task automatic test_drain();
        bus_ready = 1'b1;
        tick();
        n_run++;
        if (push_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_ready: got %b want 1", push_ready);
        end
        tick();
        set_push(1'b0, '0, '0, '0);
        tick();
        tick();
        n_run++;
        if (empty !== 1'b1 || bus_write_req !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got empty=%b req=%b want 1 0", empty, bus_write_req);
        end
    endtask

    task automatic test_simul();
        bus_ready = 1'b0;
        set_push(1'b1, 30'h30, data_of(30'h30), 4'h5);
        tick();
        bus_ready = 1'b1;
        set_push(1'b1, 30'h20, data_of(30'h20), 4'hA);
        tick();
        set_push(1'b0, '0, '0, '0);
        n_run++;
        if (count !== CW'(1) || bus_addr !== 30'h20) begin
            n_fail++;
            $display("FAIL simul_push_pop: got count=%0d addr=%h want 1 20", count, bus_addr);
        end
        tick();
    endtask

    task automatic test_query();
        bus_ready = 1'b0;
        set_push(1'b1, 30'h40, data_of(30'h40), 4'hF);
        tick();
        set_push(1'b1, 30'h44, data_of(30'h44), 4'h1);
        tick();
        set_push(1'b0, '0, '0, '0);
        query_addr = 30'h44;
        #1;
        n_run++;
        if (query_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL query_44: got %b want 1", query_hit);
        end
        query_addr = 30'h48;
        #1;
        n_run++;
        if (query_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL query_48: got %b want 0", query_hit);
        end
        query_addr = 30'h40;
        bus_ready  = 1'b1;
        #1;
        n_run++;
        if (query_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL query_head_popping: got %b want 1", query_hit);
        end
        tick();
        query_addr = 30'h44;
        #1;
        n_run++;
        if (query_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL query_44_pending: got %b want 1", query_hit);
        end
        tick();
        #1;
        n_run++;
        if (query_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL query_44_drained: got %b want 0", query_hit);
        end
        query_addr = '0;
    endtask

    task automatic test_reset_mid();
        bus_ready = 1'b0;
        set_push(1'b1, 30'h50, data_of(30'h50), 4'hF);
        tick();
        set_push(1'b1, 30'h54, data_of(30'h54), 4'hF);
        tick();
        reset_n   = 1'b0;
        bus_ready = 1'b1;
        set_push(1'b1, 30'h58, data_of(30'h58), 4'hF);
        tick();
        reset_n = 1'b1;
        set_push(1'b0, '0, '0, '0);
        #1;
        n_run++;
        if (count !== '0 || bus_write_req !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_clear: got count=%0d req=%b empty=%b want 0 0 1",
                     count, bus_write_req, empty);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++;
            if (bus_write_req !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale[%0d]: got req=%b want 0", i, bus_write_req);
            end
        end
        set_push(1'b1, 30'h60, data_of(30'h60), 4'h9);
        tick();
        set_push(1'b0, '0, '0, '0);
        n_run++;
        if (bus_addr !== 30'h60) begin
            n_fail++;
            $display("FAIL midreset_fresh: got addr=%h want 60", bus_addr);
        end
        tick();
        n_run++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_final_empty: got %b want 1", empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_hold();
        test_drain();
        test_simul();
        test_query();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
